act_func_scheduler: RTL and testbench

Arbiter/sequencer that shares one fixed-latency activation unit (sigmoid/tanh datapath) between a sigmoid requester and a tanh requester in the LSTM gate pipeline. Each cycle it grants at most one request round-robin and issues the operand with a mode bit. It tracks in-flight operations in a tag pipeline and routes each result back to the requester that issued it. An enable/drain FSM lets the LSTM controller quiesce the unit between timesteps.

---
 rtl/act_func_scheduler_pkg.sv | 6 +
 rtl/act_func_scheduler_tag_pipe.sv | 28 ++
 rtl/act_func_scheduler.sv | 75 +++++++
 tb/tb_act_func_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/act_func_scheduler_pkg.sv
// act_func_scheduler_pkg: FSM state encoding and activation mode constants shared by the scheduler
package act_func_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic MODE_SIG  = 1'b1;
  localparam logic MODE_TANH = 1'b0;
endpackage

// File: rtl/act_func_scheduler_tag_pipe.sv
// act_tag_pipe: PIPE_LAT-deep {valid, mode} shift register (in_valid/in_mode in, out_valid/out_mode from last stage)
module act_tag_pipe #(
  parameter int PIPE_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_mode,
  output logic out_valid,
  output logic out_mode
);
  logic [PIPE_LAT-1:0] v, m;
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      m <= '0;
    end else begin
      v[0] <= in_valid;
      m[0] <= in_mode;
      for (int i = 1; i < PIPE_LAT; i++) begin
        v[i] <= v[i-1];
        m[i] <= m[i-1];
      end
    end
  end
  assign out_valid = v[PIPE_LAT-1];
  assign out_mode  = m[PIPE_LAT-1];
endmodule

// File: rtl/act_func_scheduler.sv
// act_func_scheduler: round-robin sharing of one activation unit between sigmoid/tanh requesters (en/idle control, *_req/*_din/*_gnt in, act_* issue, *_valid/*_dout routed results)
module act_func_scheduler
  import act_func_scheduler_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              idle,
  input  logic              sig_req,
  input  logic [DATA_W-1:0] sig_din,
  output logic              sig_gnt,
  input  logic              tanh_req,
  input  logic [DATA_W-1:0] tanh_din,
  output logic              tanh_gnt,
  output logic              act_valid,
  output logic              act_mode,
  output logic [DATA_W-1:0] act_din,
  input  logic [DATA_W-1:0] act_dout,
  output logic              sig_valid,
  output logic [DATA_W-1:0] sig_dout,
  output logic              tanh_valid,
  output logic [DATA_W-1:0] tanh_dout
);
  localparam int CNT_W = $clog2(PIPE_LAT + 2);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] in_flight;
  logic             last_sig, grant_ok, sel_sig, tag_valid, tag_mode;
  act_tag_pipe #(.PIPE_LAT(PIPE_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (act_valid),
    .in_mode  (act_mode),
    .out_valid(tag_valid),
    .out_mode (tag_mode)
  );
  always_comb begin
    grant_ok  = ~rst & en & (state != DRAIN) & (sig_req | tanh_req);
    sel_sig   = sig_req & (~tanh_req | ~last_sig);
    sig_gnt   = grant_ok & sel_sig;
    tanh_gnt  = grant_ok & ~sel_sig;
    state_nxt = en ? RUN : (state == IDLE || (state == DRAIN && in_flight == '0)) ? IDLE : DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idle       <= 1'b1;
      last_sig   <= MODE_TANH;
      act_valid  <= 1'b0;
      act_mode   <= MODE_TANH;
      act_din    <= '0;
      sig_valid  <= 1'b0;
      tanh_valid <= 1'b0;
      sig_dout   <= '0;
      tanh_dout  <= '0;
      in_flight  <= '0;
    end else begin
      state      <= state_nxt;
      idle       <= state_nxt == IDLE;
      act_valid  <= grant_ok;
      sig_valid  <= tag_valid & (tag_mode == MODE_SIG);
      tanh_valid <= tag_valid & (tag_mode == MODE_TANH);
      in_flight  <= in_flight + CNT_W'(grant_ok) - CNT_W'(tag_valid);
      if (grant_ok) begin
        last_sig <= sel_sig;
        act_mode <= sel_sig ? MODE_SIG : MODE_TANH;
        act_din  <= sel_sig ? sig_din : tanh_din;
      end
      if (tag_valid && tag_mode == MODE_SIG) sig_dout <= act_dout;
      if (tag_valid && tag_mode == MODE_TANH) tanh_dout <= act_dout;
    end
  end
endmodule

// File: tb/tb_act_func_scheduler.sv
// tb_act_func_scheduler: directed-vector bench for act_func_scheduler with a 3-cycle activation unit model
module tb_act_func_scheduler;
  localparam int DATA_W = 16;
  logic              clk = 0, rst = 0, en = 0, idle;
  logic              sig_req = 0, tanh_req = 0, sig_gnt, tanh_gnt;
  logic [DATA_W-1:0] sig_din = 0, tanh_din = 0;
  logic              act_valid, act_mode, sig_valid, tanh_valid;
  logic [DATA_W-1:0] act_din, act_dout, sig_dout, tanh_dout;
  logic [DATA_W-1:0] p0 = 0, p1 = 0, p2 = 0;
  int tests = 0, fails = 0, peak;
  act_func_scheduler #(.DATA_W(DATA_W), .PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .idle(idle),
    .sig_req(sig_req), .sig_din(sig_din), .sig_gnt(sig_gnt),
    .tanh_req(tanh_req), .tanh_din(tanh_din), .tanh_gnt(tanh_gnt),
    .act_valid(act_valid), .act_mode(act_mode), .act_din(act_din), .act_dout(act_dout),
    .sig_valid(sig_valid), .sig_dout(sig_dout), .tanh_valid(tanh_valid), .tanh_dout(tanh_dout)
  );
  always #5 clk = ~clk;
  function automatic logic [DATA_W-1:0] unit_f(input logic [DATA_W-1:0] d);
    return (d == 16'h0100) ? 16'h00B7 : d + 16'h1000;
  endfunction
  always @(posedge clk) begin
    p0 <= unit_f(act_din);
    p1 <= p0;
    p2 <= p1;
  end
  assign act_dout = p2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; en = 0; sig_req = 0; tanh_req = 0;
    next();
    rst = 0;
  endtask
  initial begin
    #1;
    rst = 1; en = 1; sig_req = 1; sig_din = 16'h0F0F;
    #1;
    chk("rst_gnt0", {tanh_gnt, sig_gnt}, 0);
    next();
    #1;
    chk("rst_gnt1", {tanh_gnt, sig_gnt}, 0);
    chk("rst_idle", idle, 1);
    chk("rst_act", {act_valid, act_mode, act_din}, 0);
    chk("rst_out", {sig_valid, tanh_valid}, 0);
    chk("rst_dout", {sig_dout, tanh_dout}, 0);
    chk("rst_cnt", dut.in_flight, 0);
    do_reset();
    en = 1; sig_req = 1; sig_din = 16'h0100;
    #1;
    chk("s1_gnt", {sig_gnt, tanh_gnt}, 2'b10);
    next();
    sig_req = 0;
    #1;
    chk("s1_issue", {act_valid, act_mode, act_din}, {2'b11, 16'h0100});
    chk("s1_idle", idle, 0);
    for (int k = 0; k < 3; k++) begin
      next();
      chk("s1_early", {sig_valid, tanh_valid}, 0);
    end
    next();
    chk("s1_valid", {sig_valid, tanh_valid}, 2'b10);
    chk("s1_dout", sig_dout, 16'h00B7);
    chk("s1_cnt", dut.in_flight, 0);
    next();
    chk("s1_hold", {sig_valid, sig_dout}, {1'b0, 16'h00B7});
    do_reset();
    sig_din = 16'h1111; tanh_din = 16'h2222; peak = 0;
    for (int k = 0; k < 13; k++) begin
      en = 1; sig_req = k < 6; tanh_req = k < 6;
      #1;
      chk("ct_sgnt", sig_gnt, k < 6 && k % 2 == 0);
      chk("ct_tgnt", tanh_gnt, k < 6 && k % 2 == 1);
      chk("ct_sval", sig_valid, k >= 5 && k <= 10 && k % 2 == 1);
      chk("ct_tval", tanh_valid, k >= 5 && k <= 10 && k % 2 == 0);
      if (k >= 5 && k <= 10 && k % 2 == 1) chk("ct_sdout", sig_dout, 16'h2111);
      if (k >= 5 && k <= 10 && k % 2 == 0) chk("ct_tdout", tanh_dout, 16'h3222);
      if (int'(dut.in_flight) > peak) peak = int'(dut.in_flight);
      next();
    end
    chk("ct_peak", peak, 4);
    do_reset();
    tanh_din = 16'h0040;
    for (int k = 0; k < 17; k++) begin
      en = 1; sig_req = 0; tanh_req = k < 10;
      #1;
      chk("sat_gnt", {sig_gnt, tanh_gnt}, {1'b0, k < 10});
      chk("sat_val", {sig_valid, tanh_valid}, {1'b0, k >= 5 && k < 15});
      if (k >= 5 && k < 15) chk("sat_dout", tanh_dout, 16'h1040);
      if (k >= 4 && k <= 10) chk("sat_cnt", dut.in_flight, 4);
      next();
    end
    do_reset();
    sig_din = 16'h0300; tanh_din = 16'h0A0A;
    for (int k = 0; k < 11; k++) begin
      en = k < 3; sig_req = 1; tanh_req = k >= 3;
      #1;
      chk("dr_gnt", {sig_gnt, tanh_gnt}, {k < 3, 1'b0});
      chk("dr_val", {sig_valid, tanh_valid}, {k >= 5 && k <= 7, 1'b0});
      if (k >= 5 && k <= 7) chk("dr_dout", sig_dout, 16'h1300);
      chk("dr_idle", idle, k == 0 || k >= 8);
      if (k == 3) chk("dr_cnt3", dut.in_flight, 3);
      if (k == 7) chk("dr_cnt0", dut.in_flight, 0);
      next();
    end
    do_reset();
    en = 1; sig_req = 1; sig_din = 16'h0600;
    next();
    sig_req = 0; tanh_req = 1; tanh_din = 16'h0700;
    next();
    rst = 1; sig_req = 1;
    #1;
    chk("rm_gnt", {sig_gnt, tanh_gnt}, 0);
    chk("rm_cnt", dut.in_flight, 2);
    next();
    rst = 0; en = 0; sig_req = 0; tanh_req = 0;
    #1;
    chk("rm_act", {act_valid, act_mode, act_din}, 0);
    chk("rm_out", {sig_valid, tanh_valid, sig_dout, tanh_dout}, 0);
    chk("rm_idle", idle, 1);
    chk("rm_cnt0", dut.in_flight, 0);
    for (int k = 0; k < 10; k++) begin
      next();
      chk("rm_stale", {sig_valid, tanh_valid}, 0);
    end
    do_reset();
    sig_din = 16'h0500;
    for (int k = 0; k < 13; k++) begin
      en = k < 2 || k == 3 || k == 4;
      sig_req = k == 0 || k == 1 || k == 3 || k == 4;
      tanh_req = 0;
      #1;
      if (k == 3) chk("re_cnt2", dut.in_flight, 2);
      chk("re_gnt", sig_gnt, k == 0 || k == 1 || k == 4);
      chk("re_val", sig_valid, k == 5 || k == 6 || k == 9);
      if (k == 5 || k == 6 || k == 9) chk("re_dout", sig_dout, 16'h1500);
      chk("re_idle", idle, k == 0 || k >= 10);
      next();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
